ir_emitter_scan: RTL and testbench

IR_EMITTER_SCAN -- requirements
Module: ir_emitter_scan

---
 rtl/parking_pkg.sv | 26 ++
 rtl/ir_carrier_gen.sv | 52 +++++
 rtl/ir_emitter_scan.sv | 132 +++++++++++++
 tb/tb_ir_emitter_scan.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-bay IR scanner.
// Contents: scan FSM state enum, slot count (N_SLOTS), slot index width (SLOT_W)
// and a helper that turns a slot index into a one-hot emitter mask.
package parking_pkg;

    localparam int N_SLOTS = 6;
    localparam int SLOT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_e;

    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        logic [N_SLOTS-1:0] mask;
        mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (idx == SLOT_W'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// IR carrier generator.
// Produces a square wave that toggles every CARRIER_DIV clk cycles while run=1.
// Whenever run=0 (or rst=1) the phase is parked high, so every burst starts
// with a full high half-period.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   run     - carrier enable (high for the duration of a burst)
//   carrier - registered carrier output
module ir_carrier_gen #(
    parameter int CARRIER_DIV = 1316
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic carrier
);

    // CARRIER_DIV=1 would give a zero-width counter; keep at least one bit.
    localparam int DIV_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CARRIER_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        div_cnt_d = '0;
        phase_d   = 1'b1;
        if (run) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                phase_d   = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign carrier = phase_q;

endmodule

// File: rtl/ir_emitter_scan.sv
// Parking-bay IR emitter scanner.
// Cycles through N_SLOTS emitters: each slot gets a burst of
// 2*CARRIER_DIV*BURST_CYCLES cycles followed by GAP_CYCLES idle cycles. The
// receiver is told to latch ir[slot_idx] in the last burst cycle of each slot.
// Build option: define IR_TX_CARRIER_EN to modulate the active emitter with the
// carrier; otherwise the active emitter is held steady high for the burst.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset (overrides en)
//   en            - scan enable; sampled at start and at the end of each gap
//   emit[5:0]     - emitter drive, at most one bit high
//   slot_idx[2:0] - slot being scanned (0..5)
//   sample_strobe - one-cycle pulse in the last burst cycle of a slot
//   frame_done    - sample_strobe for slot 5
module ir_emitter_scan
    import parking_pkg::*;
#(
    parameter int CARRIER_DIV  = 1316,
    parameter int BURST_CYCLES = 10,
    parameter int GAP_CYCLES   = 2632
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [N_SLOTS-1:0] emit,
    output logic [SLOT_W-1:0]  slot_idx,
    output logic              sample_strobe,
    output logic              frame_done
);

    localparam int BURST_LEN = 2 * CARRIER_DIV * BURST_CYCLES;
    // One counter times both burst and gap; BURST_LEN is always >= 2.
    localparam int CNT_MAX   = (BURST_LEN > GAP_CYCLES) ? BURST_LEN : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(N_SLOTS - 1);

    scan_state_e        state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SLOTS-1:0] mask_q, mask_d;
    logic               strobe_q, strobe_d;
    logic               frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_BURST;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (cnt_q == BURST_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = ST_BURST;
                        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        strobe_d = (state_d == ST_BURST) && (cnt_d == BURST_LAST);
        frame_d  = strobe_d && (slot_d == SLOT_LAST);
        mask_d   = (state_d == ST_BURST) ? slot_onehot(slot_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
        end
    end

`ifdef IR_TX_CARRIER_EN
    logic carrier;

    ir_carrier_gen #(
        .CARRIER_DIV(CARRIER_DIV)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .run    (state_q == ST_BURST),
        .carrier(carrier)
    );

    assign emit = mask_q & {N_SLOTS{carrier}};
`else
    assign emit = mask_q;
`endif

    assign slot_idx      = slot_q;
    assign sample_strobe = strobe_q;
    assign frame_done    = frame_q;

endmodule

// File: tb/tb_ir_emitter_scan.sv
module tb_ir_emitter_scan;

    localparam int DIV   = 2;
    localparam int BC    = 3;
    localparam int GAP   = 4;
    localparam int BL    = 2 * DIV * BC;   // 12
    localparam int SLOTL = BL + GAP;       // 16

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [5:0] emit;
    logic [2:0] slot_idx;
    logic       sample_strobe;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the scan expressed as (idle, slot, t),
    // t = cycles since the start of this slot's burst.
    bit m_idle = 1'b1;
    int m_slot = 0;
    int m_t    = 0;

    ir_emitter_scan #(
        .CARRIER_DIV (DIV),
        .BURST_CYCLES(BC),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .emit         (emit),
        .slot_idx     (slot_idx),
        .sample_strobe(sample_strobe),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step(input logic r, input logic e);
        if (r) begin
            m_idle = 1'b1; m_slot = 0; m_t = 0;
        end else if (m_idle) begin
            if (e) begin m_idle = 1'b0; m_slot = 0; m_t = 0; end
        end else if (m_t == SLOTL - 1) begin
            if (e) begin m_slot = (m_slot + 1) % 6; m_t = 0; end
            else   begin m_idle = 1'b1; m_slot = 0; m_t = 0; end
        end else begin
            m_t++;
        end
    endfunction

    function automatic logic m_burst();
        return !m_idle && (m_t < BL);
    endfunction

    function automatic logic [5:0] m_emit();
        logic lvl;
`ifdef IR_TX_CARRIER_EN
        lvl = ((m_t / DIV) % 2) == 0;
`else
        lvl = 1'b1;
`endif
        return (m_burst() && lvl) ? (6'd1 << m_slot) : 6'd0;
    endfunction

    task automatic check_model();
        logic stb;
        stb = !m_idle && (m_t == BL - 1);
        chk("emit",     32'(emit),          32'(m_emit()));
        chk("slot_idx", 32'(slot_idx),      32'(m_slot));
        chk("strobe",   32'(sample_strobe), 32'(stb));
        chk("frame",    32'(frame_done),    32'(stb && (m_slot == 5)));
    endtask

    // Drive inputs, take one clock edge, then sample 1 time unit later.
    task automatic cycle(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        model_step(r, e);
        #1;
        check_model();
    endtask

    initial begin
        logic [11:0] pat;
        logic [11:0] exp_pat;
        int stb_at, gap_zero, n_stb, last_stb, n_frame, wrap_seen, prev_slot;

`ifdef IR_TX_CARRIER_EN
        exp_pat = 12'h333;
`else
        exp_pat = 12'hFFF;
`endif

        // Reset held with en=1: everything quiet.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        chk("rst_emit", 32'(emit), 32'd0);
        chk("rst_slot", 32'(slot_idx), 32'd0);

        // Release: slot 0 burst one cycle later, carrier pattern, strobe, gap, slot 1.
        cycle(1'b0, 1'b1);
        chk("rel_emit", 32'(emit), 32'h01);
        pat = '0; stb_at = -1; gap_zero = 0;
        for (int k = 0; k < BL; k++) begin
            pat[k] = emit[0];
            if (sample_strobe) stb_at = k;
            cycle(1'b0, 1'b1);
        end
        chk("burst_pattern", 32'(pat), 32'(exp_pat));
        chk("strobe_pos", 32'(stb_at), 32'd11);
        for (int g = 0; g < GAP; g++) begin
            if (emit == 6'd0) gap_zero++;
            cycle(1'b0, 1'b1);
        end
        chk("gap_zero", 32'(gap_zero), 32'd4);
        chk("slot1_emit", 32'(emit), 32'h02);

        // Full frame from slot 1: 6 strobes 16 apart, one frame_done on slot 5, wrap to 0.
        n_stb = 0; last_stb = -1; n_frame = 0; wrap_seen = 0; prev_slot = 1;
        for (int c = 0; c < 6 * SLOTL; c++) begin
            if (sample_strobe) begin
                if (last_stb >= 0) chk("strobe_spacing", 32'(c - last_stb), 32'd16);
                last_stb = c;
                n_stb++;
            end
            if (frame_done) begin
                n_frame++;
                chk("frame_slot", 32'(slot_idx), 32'd5);
                chk("frame_with_strobe", 32'(sample_strobe), 32'd1);
            end
            if (prev_slot == 5 && slot_idx == 3'd0) wrap_seen++;
            prev_slot = int'(slot_idx);
            cycle(1'b0, 1'b1);
        end
        chk("frame_strobes", 32'(n_stb), 32'd6);
        chk("frame_done_cnt", 32'(n_frame), 32'd1);
        chk("slot_wrap", 32'(wrap_seen), 32'd1);

        // Advance to slot 2, burst cycle 3, then drop en.
        for (int c = 0; c < SLOTL + 2; c++) cycle(1'b0, 1'b1);
        chk("pre_drop_slot", 32'(slot_idx), 32'd2);
        n_stb = 0; gap_zero = 0;
        for (int c = 0; c < 30; c++) begin
            if (sample_strobe) begin
                n_stb++;
                chk("drop_strobe_slot", 32'(slot_idx), 32'd2);
            end
            cycle(1'b0, 1'b0);
            if (c >= 20 && emit == 6'd0 && slot_idx == 3'd0) gap_zero++;
        end
        chk("drop_strobes", 32'(n_stb), 32'd1);
        chk("drop_idle", 32'(gap_zero), 32'd10);

        // Restart, reach slot 3 burst cycle 5, assert rst.
        cycle(1'b0, 1'b1);
        chk("restart_emit", 32'(emit), 32'h01);
        for (int c = 0; c < 3 * SLOTL + 4; c++) cycle(1'b0, 1'b1);
        chk("pre_rst_slot", 32'(slot_idx), 32'd3);
        chk("pre_rst_emit_any", 32'(emit & ~6'h08), 32'd0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b1);
            chk("midrst_emit", 32'(emit), 32'd0);
            chk("midrst_strobe", 32'(sample_strobe), 32'd0);
        end
        cycle(1'b0, 1'b1);
        chk("post_rst_emit", 32'(emit), 32'h01);
        chk("post_rst_slot", 32'(slot_idx), 32'd0);

        // Random en/rst soak.
        for (int c = 0; c < 10000; c++) begin
            logic r, e;
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 9) != 0);
            if (c % 2000 > 1500) e = ($urandom_range(0, 3) == 0);
            cycle(r, e);
            chk("soak_onehot0", 32'($onehot0(emit)), 32'd1);
            if (!m_burst()) chk("soak_quiet", 32'(emit), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
